// File: rtl/interrupt_ctrl_if.sv
// rtl/interrupt_ctrl_if.sv - CPU bus, handshake and source signals of the interrupt controller
interface interrupt_ctrl_if;
  logic [4:0]  irq_src;
  logic [4:0]  src_ack;
  logic [15:0] address;
  logic [7:0]  din;
  logic        we_n;
  logic [7:0]  dout;
  logic        ime;
  logic        int_req;
  logic        cpu_ack;
  logic [15:0] vector;
  logic        wake;

  modport master (
    output irq_src, address, din, we_n, ime, cpu_ack,
    input  src_ack, dout, int_req, vector, wake
  );

  modport slave (
    input  irq_src, address, din, we_n, ime, cpu_ack,
    output src_ack, dout, int_req, vector, wake
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - IF/IE registers, edge capture, fixed-priority arbitration and CPU handshake
module interrupt_ctrl (
  input logic           clk,
  input logic           Reset,
  interrupt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

  state_t      state, state_next;
  logic [4:0]  if_q, prev_q, src_ack_q;
  logic [7:0]  ie_q;
  logic [15:0] vector_q;
  logic [4:0]  rise, pend, clr, win_onehot;
  logic [15:0] win_vector;
  logic        wr_if, wr_ie, take_ack;

  assign rise  = bus.irq_src & ~prev_q;
  assign pend  = if_q & ie_q[4:0];
  assign wr_if = !bus.we_n && (bus.address == 16'hFF0F);
  assign wr_ie = !bus.we_n && (bus.address == 16'hFFFF);

  // Scan from the lowest-priority bit upward so the lowest set bit is left standing.
  always_comb begin
    win_onehot = '0;
    win_vector = 16'h0040;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) begin
        win_onehot = 5'b00001 << i;
        win_vector = 16'h0040 + (16'(i) << 3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr        = '0;
    take_ack   = 1'b0;
    case (state)
      IDLE:  if (bus.ime && pend != 5'd0) state_next = REQ;
      REQ: begin
        if (!bus.ime || pend == 5'd0) begin
          state_next = IDLE;
        end else if (bus.cpu_ack) begin
          take_ack   = 1'b1;
          clr        = win_onehot;
          state_next = SERVE;
        end
      end
      SERVE: if (!bus.cpu_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rising edge in the same cycle as a clear or write always leaves its bit set.
  always_ff @(posedge clk) begin
    if (Reset) begin
      if_q      <= '0;
      ie_q      <= '0;
      prev_q    <= '0;
      vector_q  <= '0;
      src_ack_q <= '0;
    end else begin
      prev_q    <= bus.irq_src;
      if_q      <= ((wr_if ? bus.din[4:0] : if_q) & ~clr) | rise;
      if (wr_ie) ie_q <= bus.din;
      if (take_ack) vector_q <= win_vector;
      src_ack_q <= take_ack ? win_onehot : 5'd0;
    end
  end

  always_comb begin
    case (bus.address)
      16'hFF0F: bus.dout = {3'b111, if_q};
      16'hFFFF: bus.dout = ie_q;
      default:  bus.dout = 8'hFF;
    endcase
  end

  assign bus.int_req = (state == REQ);
  assign bus.vector  = vector_q;
  assign bus.src_ack = src_ack_q;
  assign bus.wake    = |pend;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - scoreboard bench for interrupt_ctrl with a behavioural reference model
module tb_interrupt_ctrl;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  interrupt_ctrl_if bus();

  interrupt_ctrl dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: phase 0 = no request, 1 = requesting, 2 = being serviced.
  logic [4:0]  m_if   = '0;
  logic [4:0]  m_prev = '0;
  logic [7:0]  m_ie   = '0;
  logic [15:0] m_vec  = '0;
  int          m_phase = 0;

  logic [20:0] exp_q[$];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  function automatic logic [7:0] m_read(logic [15:0] a);
    if (a == 16'hFF0F) return {3'b111, m_if};
    if (a == 16'hFFFF) return m_ie;
    return 8'hFF;
  endfunction

  task automatic step();
    logic [4:0]  pend, clr, nif;
    logic [15:0] nvec;
    int          nphase, idx;
    pend   = m_if & m_ie[4:0];
    clr    = '0;
    nvec   = m_vec;
    nphase = m_phase;
    if (m_phase == 0) begin
      if (bus.ime && pend != 0) nphase = 1;
    end else if (m_phase == 1) begin
      if (!bus.ime || pend == 0) begin
        nphase = 0;
      end else if (bus.cpu_ack) begin
        idx = 0;
        while (idx < 4 && !pend[idx]) idx++;
        clr    = 5'(1 << idx);
        nvec   = 16'(64 + 8 * idx);
        nphase = 2;
        if (!Reset) exp_q.push_back({clr, nvec});
      end
    end else if (!bus.cpu_ack) begin
      nphase = 0;
    end
    nif = (((!bus.we_n && bus.address == 16'hFF0F) ? bus.din[4:0] : m_if) & ~clr)
          | (bus.irq_src & ~m_prev);
    @(posedge clk);
    if (Reset) begin
      m_if = '0; m_ie = '0; m_prev = '0; m_vec = '0; m_phase = 0;
    end else begin
      m_if = nif;
      if (!bus.we_n && bus.address == 16'hFFFF) m_ie = bus.din;
      m_prev  = bus.irq_src;
      m_vec   = nvec;
      m_phase = nphase;
    end
    #1;
    chk("int_req", 16'(bus.int_req), 16'(m_phase == 1));
    chk("wake", 16'(bus.wake), 16'(|(m_if & m_ie[4:0])));
    chk("vector", bus.vector, m_vec);
    chk("dout", 16'(bus.dout), 16'(m_read(bus.address)));
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    bus.address = a;
    bus.din     = d;
    bus.we_n    = 1'b0;
    step();
    bus.we_n    = 1'b1;
    bus.address = 16'hFF0F;
  endtask

  always @(negedge clk) begin
    if (bus.src_ack !== 5'd0) begin
      logic [20:0] e;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL src_ack_unexpected: got ack=%b vec=0x%h expected no pulse", bus.src_ack, bus.vector);
      end else begin
        e = exp_q.pop_front();
        if ({bus.src_ack, bus.vector} === e) n_pass++;
        else $display("FAIL src_ack: got ack=%b vec=0x%h expected ack=%b vec=0x%h",
                      bus.src_ack, bus.vector, e[20:16], e[15:0]);
      end
    end
  end

  initial begin
    logic [4:0] flip;
    Reset = 1'b1;
    bus.irq_src = '0; bus.address = 16'hFF0F; bus.din = '0;
    bus.we_n = 1'b1; bus.ime = 1'b0; bus.cpu_ack = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();
    chk("rst_if", 16'(bus.dout), 16'h00E0);
    bus.address = 16'hFFFF; #1;
    chk("rst_ie", 16'(bus.dout), 16'h0000);
    bus.address = 16'hFF0F;
    chk("rst_int_req", 16'(bus.int_req), 16'h0);
    chk("rst_vector", bus.vector, 16'h0000);

    // timer request
    wr(16'hFFFF, 8'h04);
    bus.ime = 1'b1;
    bus.irq_src = 5'b00100;
    step();
    chk("tmr_if", 16'(bus.dout), 16'h00E4);
    chk("tmr_req_early", 16'(bus.int_req), 16'h0);
    step();
    chk("tmr_req", 16'(bus.int_req), 16'h1);
    bus.cpu_ack = 1'b1;
    step();
    chk("tmr_vector", bus.vector, 16'h0050);
    chk("tmr_src_ack", 16'(bus.src_ack), 16'h0004);
    chk("tmr_if_clr", 16'(bus.dout), 16'h00E0);
    step();
    chk("tmr_src_ack_one", 16'(bus.src_ack), 16'h0000);
    bus.cpu_ack = 1'b0;
    step();
    bus.irq_src = '0;
    step();

    // priority: timer and joypad together
    wr(16'hFFFF, 8'h1F);
    bus.irq_src = 5'b10100;
    step(); step();
    bus.cpu_ack = 1'b1;
    step();
    chk("pri_vec1", bus.vector, 16'h0050);
    chk("pri_if1", 16'(bus.dout), 16'h00F0);
    bus.cpu_ack = 1'b0;
    step(); step();
    bus.cpu_ack = 1'b1;
    step();
    chk("pri_vec2", bus.vector, 16'h0060);
    chk("pri_if2", 16'(bus.dout), 16'h00E0);
    bus.cpu_ack = 1'b0;
    bus.irq_src = '0;
    step();

    // software cancel while requesting
    bus.irq_src = 5'b00001;
    step(); step();
    chk("cancel_req", 16'(bus.int_req), 16'h1);
    wr(16'hFF0F, 8'h00);
    step();
    chk("cancel_drop", 16'(bus.int_req), 16'h0);
    bus.cpu_ack = 1'b1;
    step(); step();
    chk("cancel_no_ack", 16'(bus.src_ack), 16'h0000);
    bus.cpu_ack = 1'b0;
    bus.irq_src = '0;
    step();

    // write collides with an edge; wake without ime
    bus.ime = 1'b0;
    wr(16'hFFFF, 8'h01);
    bus.irq_src = 5'b00001;
    wr(16'hFF0F, 8'h00);
    chk("coll_if", 16'(bus.dout), 16'h00E1);
    chk("coll_wake", 16'(bus.wake), 16'h1);
    step(); step();
    chk("coll_no_req", 16'(bus.int_req), 16'h0);
    bus.irq_src = '0;
    wr(16'hFF0F, 8'h00);

    // reset while servicing
    bus.ime = 1'b1;
    bus.irq_src = 5'b00001;
    step(); step();
    bus.cpu_ack = 1'b1;
    step();
    chk("srv_vector", bus.vector, 16'h0040);
    Reset = 1'b1;
    step();
    chk("rst_srv_ack", 16'(bus.src_ack), 16'h0000);
    chk("rst_srv_vec", bus.vector, 16'h0000);
    chk("rst_srv_if", 16'(bus.dout), 16'h00E0);
    Reset = 1'b0;
    bus.irq_src = '0;
    step(); step();
    chk("rst_srv_idle", 16'(bus.int_req), 16'h0);
    bus.cpu_ack = 1'b0;
    step();

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      flip = '0;
      for (int b = 0; b < 5; b++) flip[b] = ($urandom_range(0, 7) == 0);
      bus.irq_src = bus.irq_src ^ flip;
      bus.ime     = ($urandom_range(0, 9) != 0);
      bus.cpu_ack = ($urandom_range(0, 4) < 2);
      bus.we_n    = ($urandom_range(0, 11) != 0);
      bus.din     = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 2:    bus.address = 16'hFF0F;
        1:       bus.address = 16'hFFFF;
        default: bus.address = 16'($urandom);
      endcase
      Reset = ($urandom_range(0, 299) == 0);
      step();
    end

    Reset = 1'b0;
    bus.we_n = 1'b1; bus.cpu_ack = 1'b0; bus.irq_src = '0; bus.address = 16'hFF0F;
    step(); step(); step();
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt controller sitting directly downstream of the timer and the other peripheral interrupt sources (VBlank, LCD STAT, serial, joypad). It holds the IF (0xFF0F) and IE (0xFFFF) registers, turns source request edges into pending flags, and arbitrates by fixed priority. It runs a request/acknowledge handshake with the CPU, supplies the dispatch vector, and returns a one-cycle acknowledge pulse to the serviced source; the timer's `int_a` is driven from this pulse.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- irq_src  in  5  source requests, level: [0] VBlank, [1] STAT, [2] timer, [3] serial, [4] joypad
- src_ack  out  5  one-cycle acknowledge to the serviced source; src_ack[2] drives timer int_a
- address  in  16  CPU bus address
- din  in  8  CPU write data
- we_n  in  1  active-low write strobe, one cycle per write
- dout  out  8  read data, combinational from address
- ime  in  1  CPU master interrupt enable
- int_req  out  1  interrupt request to CPU
- cpu_ack  in  1  CPU acknowledge, level, four-phase
- vector  out  16  dispatch address of the serviced interrupt
- wake  out  1  HALT wake: any (IF & IE)[4:0] set, independent of ime

## Operation
- Edge detect: `prev` register (5 bits) samples irq_src every cycle. `rise = irq_src & ~prev`. A source held high out of reset produces a rise on the first cycle after Reset deasserts.
- IF update, every cycle: `IF_next = (wr_FF0F ? din[4:0] : IF) & ~clr | rise`. `clr` is the one-hot bit being acknowledged this cycle. Priority order: a rising edge beats an ack-clear and a write; a write beats the old value.
- IE: write at 0xFFFF stores all 8 bits. Only IE[4:0] take part in arbitration.
- `pend = IF & IE[4:0]`. Winner is the lowest set bit of `pend` (bit 0 highest priority).
- Vectors: bit0 0x0040, bit1 0x0048, bit2 0x0050, bit3 0x0058, bit4 0x0060.
- Reads:
  - 0xFF0F returns {3'b111, IF}.
  - 0xFFFF returns IE.
  - Any other address returns 0xFF.
- State machine:
  - IDLE: int_req=0. Goes to REQ when `ime && pend != 0`.
  - REQ: int_req=1. Goes back to IDLE if `ime==0` or `pend==0` (for example IF cleared by software).
    - If `cpu_ack==1` and `pend != 0`, it latches the winner index and its vector and sets `clr` to the winner bit in that same cycle.
    - It then arms src_ack[winner] for the next cycle and goes to SERVE.
  - SERVE: int_req=0 and vector holds the latched value. Goes to IDLE when cpu_ack==0.
- Arbitration is re-evaluated in the cycle cpu_ack is sampled, so a higher-priority flag that arrived during REQ wins.
- cpu_ack high in IDLE is ignored: no clear, no src_ack.
- Reset values: IF=0, IE=0, prev=0, state=IDLE, int_req=0, vector=0x0000, src_ack=0, wake=0.
- Reset asserted mid-handshake returns to IDLE with no src_ack pulse; cpu_ack is then ignored until the next REQ.

## Timing
- Source edge at cycle N: IF bit set at N+1, wake high at N+1 if IE enabled. REQ is entered at N+2 if ime=1, so int_req is high from N+2.
- cpu_ack sampled high in REQ at cycle M, all effective at M+1:
  - IF bit is clear.
  - src_ack[winner]=1 for exactly one cycle (M+1).
  - int_req=0 and vector is valid, held until IDLE.
- A new edge on the same source during M: the bit stays set (edge wins), and src_ack still pulses.
- An IF write takes effect the next cycle; an edge in the same cycle ORs onto the written value.
- src_ack is never asserted for more than one cycle, and never for more than one bit.
- dout has zero latency, combinational from address and current registers.

## Test plan
- Reset, then read: dout@FF0F=0xE0, dout@FFFF=0x00; int_req=0, vector=0x0000.
- Timer request: IE=0x04, ime=1, irq_src[2] rises at N → IF=0x04 at N+1 and int_req=1 at N+2. cpu_ack high → next cycle vector=0x0050, src_ack=0b00100 for one cycle, IF=0x00. cpu_ack low → IDLE.
- Priority: IE=0x1F, irq_src 0b10100 rise together → first ack gives vector=0x0050 and IF=0x10. A second handshake gives vector=0x0060 and IF=0x00.
- Software cancel: in REQ, write FF0F=0x00 → int_req drops next cycle; a later cpu_ack yields no src_ack.
- Collision: write FF0F=0x00 in the same cycle as irq_src[0] rising → IF=0x01. With ime=0 and IE=0x01: wake=1, int_req stays 0.
- Reset in SERVE → state IDLE, src_ack=0, IF=0, vector=0x0000 on the following cycle.
